// File: rtl/lut_sweep_pkg.sv
// Shared types and default sizing for the truth-table sweep block.
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_IN_DEF = 4;
    localparam int HOLD_DEF = 1;

endpackage

// File: rtl/lut_sweep_hold_timer.sv
// Down-counter that marks the last of HOLD cycles after each load.
module hold_timer #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam logic [7:0] RELOAD = 8'(HOLD - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Counter parks at zero, so last stays asserted until the next load.
    assign last = (cnt == 8'd0);

endmodule

// File: rtl/lut_sweep.sv
// Applies every input vector to a loadable truth table, recording each output and the count of ones.
module lut_sweep
    import lut_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int HOLD = HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tt_load,
    input  logic [2**N_IN-1:0]   tt_data,
    input  logic [N_IN-1:0]      man_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 y_out,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN:0]        ones_cnt,
    output logic [2**N_IN-1:0]   sig
);

    localparam int NV = 2**N_IN;

    state_t          state;
    logic [NV-1:0]   table_q;
    logic [NV-1:0]   table_eff;
    logic [N_IN-1:0] vec_nxt;
    logic            last;
    logic            last_vec;
    logic            tmr_load;

    // A load on the same edge as start must already feed vector 0.
    assign table_eff = tt_load ? tt_data : table_q;
    assign vec_nxt   = vec_out + N_IN'(1);
    assign last_vec  = &vec_out;
    assign tmr_load  = (state == RUN) ? (last && !last_vec) : start;

    hold_timer #(.HOLD(HOLD)) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            table_q  <= '0;
            vec_out  <= '0;
            y_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
            sig      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (tt_load) begin
                        table_q <= tt_data;
                    end
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ones_cnt <= '0;
                        sig      <= '0;
                        vec_out  <= '0;
                        y_out    <= table_eff[0];
                    end else begin
                        vec_out  <= man_in;
                        y_out    <= table_eff[man_in];
                    end
                end
                RUN: begin
                    if (last) begin
                        sig[vec_out] <= y_out;
                        ones_cnt     <= ones_cnt + {{N_IN{1'b0}}, y_out};
                        if (last_vec) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vec_out <= man_in;
                            y_out   <= table_q[man_in];
                        end else begin
                            vec_out <= vec_nxt;
                            y_out   <= table_q[vec_nxt];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_sweep.sv
// Directed bench for lut_sweep: three parameterisations driven against a queue of expected vectors.
module tb_lut_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v;
    logic [2:0]  load_v;
    logic [31:0] tt;
    logic [4:0]  man;

    logic [3:0]  vec_a, vec_b;
    logic [4:0]  vec_c;
    logic        y_a, y_b, y_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [4:0]  ones_a, ones_b;
    logic [5:0]  ones_c;
    logic [15:0] sig_a, sig_b;
    logic [31:0] sig_c;

    int          total  = 0;
    int          passed = 0;
    logic [5:0]  sb_q[$];

    always #5 clk = ~clk;

    lut_sweep #(.N_IN(4), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .tt_load(load_v[0]),
        .tt_data(tt[15:0]), .man_in(man[3:0]), .vec_out(vec_a), .y_out(y_a),
        .busy(busy_a), .done(done_a), .ones_cnt(ones_a), .sig(sig_a)
    );

    lut_sweep #(.N_IN(4), .HOLD(3)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .tt_load(load_v[1]),
        .tt_data(tt[15:0]), .man_in(man[3:0]), .vec_out(vec_b), .y_out(y_b),
        .busy(busy_b), .done(done_b), .ones_cnt(ones_b), .sig(sig_b)
    );

    lut_sweep #(.N_IN(5), .HOLD(2)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .tt_load(load_v[2]),
        .tt_data(tt), .man_in(man), .vec_out(vec_c), .y_out(y_c),
        .busy(busy_c), .done(done_c), .ones_cnt(ones_c), .sig(sig_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic get(input int sel, output logic [4:0] v, output logic y, output logic b,
                       output logic d, output logic [5:0] o, output logic [31:0] s);
        case (sel)
            0: begin
                v = {1'b0, vec_a}; y = y_a; b = busy_a; d = done_a;
                o = {1'b0, ones_a}; s = {16'h0, sig_a};
            end
            1: begin
                v = {1'b0, vec_b}; y = y_b; b = busy_b; d = done_b;
                o = {1'b0, ones_b}; s = {16'h0, sig_b};
            end
            default: begin
                v = vec_c; y = y_c; b = busy_c; d = done_c; o = ones_c; s = sig_c;
            end
        endcase
    endtask

    // Load-and-start on one edge, then follow the sweep cycle by cycle against the queue.
    task automatic sweep(input int sel, input logic [31:0] t, input int n, input int hold, input bit inject);
        int          nv, limit, runlen, pc;
        logic [4:0]  v;
        logic        y, b, d;
        logic [5:0]  o, e;
        logic [31:0] s, mask;
        nv    = 1 << n;
        limit = nv * hold + 8;
        mask  = (n == 5) ? 32'hFFFF_FFFF : ((32'd1 << nv) - 32'd1);
        pc    = 0;
        for (int k = 0; k < nv; k++) begin
            if (t[k]) pc++;
            for (int h = 0; h < hold; h++) sb_q.push_back({5'(k), t[k]});
        end
        @(negedge clk);
        tt = t; load_v[sel] = 1'b1; start_v[sel] = 1'b1;
        @(posedge clk); #1;
        load_v[sel] = 1'b0; start_v[sel] = 1'b0;
        runlen = 0;
        for (int c = 0; c < limit; c++) begin
            get(sel, v, y, b, d, o, s);
            if (!b || sb_q.size() == 0) break;
            e = sb_q.pop_front();
            chk("run_vec", {27'd0, v}, {27'd0, e[5:1]});
            chk("run_y", {31'd0, y}, {31'd0, e[0]});
            if (c == 0) chk("done_low_in_run", {31'd0, d}, 32'd0);
            runlen++;
            if (inject && c == 5) begin
                tt = 32'hFFFF_FFFF; load_v[sel] = 1'b1; start_v[sel] = 1'b1;
            end
            if (inject && c == 6) begin
                load_v[sel] = 1'b0; start_v[sel] = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("run_len", 32'(runlen), 32'(nv * hold));
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("done_after", {31'd0, d}, 32'd1);
        chk("ones_cnt", {26'd0, o}, 32'(pc));
        chk("sig", s, t & mask);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  v;
        logic        y, b, d, found;
        logic [5:0]  o, e;
        logic [31:0] s;

        start_v = '0; load_v = '0; tt = '0; man = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i += 2) begin
            get(i, v, y, b, d, o, s);
            chk("rst_vec", {27'd0, v}, 32'd0);
            chk("rst_y", {31'd0, y}, 32'd0);
            chk("rst_busy", {31'd0, b}, 32'd0);
            chk("rst_done", {31'd0, d}, 32'd0);
            chk("rst_ones", {26'd0, o}, 32'd0);
            chk("rst_sig", s, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // AND4, XOR4 with HOLD=3
        sweep(0, 32'h0000_8000, 4, 1, 1'b0);
        sweep(1, 32'h0000_6996, 4, 3, 1'b0);

        // Manual mode
        @(negedge clk);
        tt = 32'h0000_00F0; load_v[0] = 1'b1; man = 5'd5;
        sb_q.push_back({5'd5, 1'b1});
        @(posedge clk); #1;
        load_v[0] = 1'b0;
        get(0, v, y, b, d, o, s);
        e = sb_q.pop_front();
        chk("man_vec5", {27'd0, v}, {27'd0, e[5:1]});
        chk("man_y5", {31'd0, y}, {31'd0, e[0]});
        man = 5'd9;
        sb_q.push_back({5'd9, 1'b0});
        @(posedge clk); #1;
        get(0, v, y, b, d, o, s);
        e = sb_q.pop_front();
        chk("man_vec9", {27'd0, v}, {27'd0, e[5:1]});
        chk("man_y9", {31'd0, y}, {31'd0, e[0]});

        // Start from DONE, with a load and a second start during RUN
        sweep(0, 32'h0000_5A3C, 4, 1, 1'b1);

        // Reset in the middle of a sweep
        @(negedge clk);
        tt = 32'h0000_6996; load_v[1] = 1'b1; start_v[1] = 1'b1; man = 5'd1;
        @(posedge clk); #1;
        load_v[1] = 1'b0; start_v[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            get(1, v, y, b, d, o, s);
            if (b && v == 5'd7) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_vec7", {31'd0, found}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        get(1, v, y, b, d, o, s);
        chk("mid_rst_busy", {31'd0, b}, 32'd0);
        chk("mid_rst_done", {31'd0, d}, 32'd0);
        chk("mid_rst_ones", {26'd0, o}, 32'd0);
        chk("mid_rst_sig", s, 32'd0);
        chk("mid_rst_vec", {27'd0, v}, 32'd0);
        @(posedge clk); #1;
        get(1, v, y, b, d, o, s);
        chk("mid_rst_man_vec", {27'd0, v}, 32'd1);
        chk("mid_rst_table_clr", {31'd0, y}, 32'd0);
        sweep(1, 32'h0000_C3A5, 4, 3, 1'b0);

        // Five inputs, HOLD=2
        sweep(2, 32'hFFFF_FFFF, 5, 2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
